// File: rtl/pipeline_stall_controller_pkg.sv
// Purpose  : shared types and constants for the pipeline stall/flush sequencer.
// Latency  : n/a (declarations only).
// Backpres.: n/a.
// Contents : state_e FSM encoding, register-address width, default sizing,
//            load-use hazard helper.
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W      = 5;
  localparam int MEM_TIMEOUT_DEF = 16;
  localparam int CNT_W_DEF       = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  // The MemRead gate covers both source compares; x0 is never a real
  // producer so it can never create a hazard.
  function automatic logic load_use_hazard(
    input logic                  ex_mem_read,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic [REG_ADDR_W-1:0] id_rs1,
    input logic [REG_ADDR_W-1:0] id_rs2
  );
    return ex_mem_read && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Purpose  : bundle of hazard inputs, memory handshake and control outputs.
// Latency  : n/a (wires only).
// Backpres.: dmem_req_o / dmem_ready_i form the memory handshake.
// Modports : master = pipeline/memory side (drives hazard info, ready),
//            slave  = stall controller (drives enables, flush, bubble, counters).
interface pipeline_stall_controller_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic [REG_ADDR_W-1:0] ID_Rs1_i;
  logic [REG_ADDR_W-1:0] ID_Rs2_i;
  logic [REG_ADDR_W-1:0] EX_Rd_i;
  logic                  EX_MemRead_i;
  logic                  ID_BranchTaken_i;
  logic                  MEM_MemRead_i;
  logic                  MEM_MemWrite_i;
  logic                  dmem_ready_i;

  logic                  PCWrite_o;
  logic                  IF_ID_Write_o;
  logic                  ID_EX_Write_o;
  logic                  EX_MEM_Write_o;
  logic                  MEM_WB_Write_o;
  logic                  IF_ID_Flush_o;
  logic                  NoOp_o;
  logic                  dmem_req_o;
  logic                  err_o;
  logic [CNT_W-1:0]      stall_cnt_o;
  logic [CNT_W-1:0]      flush_cnt_o;

  modport master (
    output ID_Rs1_i, ID_Rs2_i, EX_Rd_i, EX_MemRead_i, ID_BranchTaken_i,
           MEM_MemRead_i, MEM_MemWrite_i, dmem_ready_i,
    input  PCWrite_o, IF_ID_Write_o, ID_EX_Write_o, EX_MEM_Write_o,
           MEM_WB_Write_o, IF_ID_Flush_o, NoOp_o, dmem_req_o, err_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  ID_Rs1_i, ID_Rs2_i, EX_Rd_i, EX_MemRead_i, ID_BranchTaken_i,
           MEM_MemRead_i, MEM_MemWrite_i, dmem_ready_i,
    output PCWrite_o, IF_ID_Write_o, ID_EX_Write_o, EX_MEM_Write_o,
           MEM_WB_Write_o, IF_ID_Flush_o, NoOp_o, dmem_req_o, err_o,
           stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Purpose  : up-counter that sticks at all-ones instead of wrapping.
// Latency  : count visible one clk_i edge after inc is sampled high.
// Backpres.: none; inc is ignored once saturated.
// Ports    : clk_i, rst_i (async active-low), inc, cnt[W-1:0].
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Purpose  : turns load-use hazards, taken branches and slow data memory into
//            per-stage register enables, an IF/ID flush and an ID/EX bubble.
// Latency  : all controls are combinational from state and inputs; state,
//            wait counter and perf counters update on the next clk_i edge.
// Backpres.: a pending memory access freezes every pipeline register until
//            dmem_ready_i; a wait longer than MEM_TIMEOUT locks into ERROR.
// Ports    : clk_i, rst_i (async active-low), bus (slave modport).
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  pipeline_stall_controller_if.slave  bus
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W-1:0] wait_inc;

  logic mem_access;
  logic load_use;
  logic run_cycle;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic if_id_flush, no_op, dmem_req;

  assign mem_access = bus.MEM_MemRead_i | bus.MEM_MemWrite_i;
  assign load_use   = load_use_hazard(bus.EX_MemRead_i, bus.EX_Rd_i,
                                      bus.ID_Rs1_i, bus.ID_Rs2_i);
  assign wait_inc   = wait_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    run_cycle    = 1'b0;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_write  = 1'b0;
    ex_mem_write = 1'b0;
    mem_wb_write = 1'b0;
    if_id_flush  = 1'b0;
    no_op        = 1'b0;
    dmem_req     = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_access && !bus.dmem_ready_i) begin
          // Access not served in its first cycle: freeze and start timing.
          dmem_req = 1'b1;
          state_d  = MEM_WAIT;
          wait_d   = WAIT_W'(1);
        end else begin
          run_cycle = 1'b1;
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (bus.dmem_ready_i) begin
          // Completion cycle advances the pipeline like a normal RUN cycle.
          run_cycle = 1'b1;
          state_d   = RUN;
          wait_d    = '0;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TIMEOUT_V) begin
            state_d = ERROR;
          end
        end
      end
      ERROR: begin
        // Everything frozen until reset.
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase

    if (run_cycle) begin
      dmem_req     = dmem_req | mem_access;
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
      id_ex_write  = 1'b1;
      if (load_use) begin
        // Hold PC and IF/ID, bubble ID/EX. A concurrent taken branch is
        // dropped here and re-resolves when the instruction retries in ID.
        no_op = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = bus.ID_BranchTaken_i;
      end
    end

    if (!rst_i) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
      if_id_flush  = 1'b0;
      no_op        = 1'b0;
      dmem_req     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign bus.PCWrite_o      = pc_write;
  assign bus.IF_ID_Write_o  = if_id_write;
  assign bus.ID_EX_Write_o  = id_ex_write;
  assign bus.EX_MEM_Write_o = ex_mem_write;
  assign bus.MEM_WB_Write_o = mem_wb_write;
  assign bus.IF_ID_Flush_o  = if_id_flush;
  assign bus.NoOp_o         = no_op;
  assign bus.dmem_req_o     = dmem_req;
  assign bus.err_o          = (state_q == ERROR);

  // Stall cycles include ERROR; reset itself holds both counters at zero.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (!pc_write),
    .cnt   (bus.stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (if_id_flush),
    .cnt   (bus.flush_cnt_o)
  );

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Central stall/flush sequencer for the 5-stage pipeline CPU. It combines load-use hazard detection, ID-stage branch-taken flushes and a variable-latency data-memory handshake into per-stage pipeline-register write enables, a bubble and a flush. A wait/timeout FSM covers slow memory. Saturating performance counters report stall and flush cycles.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before fatal error (≥2)
CNT_W, 16, width of stall/flush performance counters

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
ID_Rs1_i  in  5  rs1 of instruction in ID
ID_Rs2_i  in  5  rs2 of instruction in ID
EX_Rd_i  in  5  rd of instruction in EX
EX_MemRead_i  in  1  EX instruction is a load
ID_BranchTaken_i  in  1  branch in ID resolved taken
MEM_MemRead_i  in  1  MEM instruction is a load
MEM_MemWrite_i  in  1  MEM instruction is a store
dmem_ready_i  in  1  data memory completes access this cycle
PCWrite_o  out  1  PC update enable
IF_ID_Write_o  out  1  IF/ID register enable
ID_EX_Write_o  out  1  ID/EX register enable
EX_MEM_Write_o  out  1  EX/MEM register enable
MEM_WB_Write_o  out  1  MEM/WB register enable
IF_ID_Flush_o  out  1  clear IF/ID to NOP
NoOp_o  out  1  insert bubble into ID/EX
dmem_req_o  out  1  data-memory request
err_o  out  1  sticky memory-timeout error
stall_cnt_o  out  CNT_W  cycles with PCWrite_o=0, saturating
flush_cnt_o  out  CNT_W  cycles with IF_ID_Flush_o=1, saturating

Behaviour:
- States: RUN, MEM_WAIT, ERROR. Reset → RUN, wait counter 0, err_o 0, both counters 0.
- While rst_i low: all *_Write_o, IF_ID_Flush_o, NoOp_o, dmem_req_o = 0.
- mem_access = MEM_MemRead_i | MEM_MemWrite_i.
- load_use = EX_MemRead_i & (EX_Rd_i != 0) & ((EX_Rd_i == ID_Rs1_i) | (EX_Rd_i == ID_Rs2_i)). The whole OR is gated by EX_MemRead_i. x0 never hazards.
- All outputs are combinational from state and inputs. State and counters are registered.
- RUN, mem_access & !dmem_ready_i:
  - dmem_req_o=1, all write enables 0, no flush/bubble.
  - next state MEM_WAIT, wait counter ← 1.
- RUN otherwise:
  - dmem_req_o = mem_access; EX_MEM/MEM_WB enables 1.
  - If load_use: PCWrite_o=0, IF_ID_Write_o=0, NoOp_o=1, ID_EX_Write_o=1, flush suppressed. load_use wins over branch; the branch re-resolves next cycle.
  - Else if ID_BranchTaken_i: IF_ID_Flush_o=1, all enables 1.
  - Else: all enables 1.
- MEM_WAIT:
  - dmem_req_o=1; the pipeline is frozen (all enables 0, no flush/bubble) until dmem_ready_i.
  - On dmem_ready_i: that cycle behaves exactly as RUN with the access complete (load_use/branch rules apply); next state RUN.
  - Else wait counter increments. When it reaches MEM_TIMEOUT: next state ERROR.
  - Zero-wait access (ready in the request cycle) never leaves RUN.
- ERROR: all enables 0, dmem_req_o=0, err_o=1. Held until reset.
- Counters saturate at 2^CNT_W−1 and never wrap:
  - stall_cnt_o increments on every cycle with PCWrite_o=0 outside reset, including in ERROR.
  - flush_cnt_o increments on IF_ID_Flush_o=1.
- Async reset mid-MEM_WAIT returns to RUN immediately with dmem_req_o=0.

Decomposition:
- Package pipeline_ctrl_pkg: state enum {RUN, MEM_WAIT, ERROR}, REG_ADDR_W=5, default MEM_TIMEOUT/CNT_W constants.
- Sub-module sat_counter (width param, inc, async active-low reset), instantiated twice for the stall and flush counters.

Test Plan:
- EX load rd=5, ID rs2=5, dmem idle → PCWrite_o=0, IF_ID_Write_o=0, NoOp_o=1 for 1 cycle; stall_cnt_o=1.
- EX load rd=0, ID rs1=0 → no stall. Non-load EX rd=5, rs1=5 → no stall, confirming the MemRead gating covers both compares.
- ID_BranchTaken_i=1 with no hazard → IF_ID_Flush_o=1, all enables 1, flush_cnt_o=1. Same with load_use=1 → NoOp_o=1, IF_ID_Flush_o=0.
- MEM load, dmem_ready_i low 3 cycles then high:
  - dmem_req_o high 4 cycles, all enables 0 for 3 cycles, then 1.
  - Back in RUN; stall_cnt_o=3.
- dmem_ready_i never asserted, MEM_TIMEOUT=4 → ERROR after 4 wait cycles, err_o=1 sticky, dmem_req_o=0, enables 0. Deassert rst_i → all clear.
- CNT_W=4, continuous load-use for 20 cycles → stall_cnt_o saturates at 15.
